apb_led_pwm: RTL



---
 rtl/apb_led_pwm_pkg.sv | 11 +
 rtl/apb_if.sv | 29 ++
 rtl/led_pwm_channel.sv | 36 +++
 rtl/apb_led_pwm.sv | 138 +++++++++++++
 4 files changed

// File: rtl/apb_led_pwm_pkg.sv
// Shared constants for the APB LED PWM block: register offsets and CTRL bit positions.
package apb_led_pwm_pkg;

  localparam logic [9:0] REG_CTRL      = 10'h000;
  localparam logic [9:0] REG_PRESCALE  = 10'h004;
  localparam logic [9:0] REG_DUTY_BASE = 10'h008;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_INVERT_BIT = 1;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle carrying the peripheral clock and reset alongside the transfer signals.
interface apb_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk,
  input logic preset_n
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport completer (
    input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport requester (
    input  pclk, preset_n, prdata, pready, pslverr,
    output psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow duty written by software, active duty that only changes
// at a frame boundary (or on enable), and a registered compare against the frame count.
module led_pwm_channel (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       shadow_we,
  input  logic [7:0] wdata,
  input  logic       load,
  input  logic       enable,
  input  logic       invert,
  input  logic [7:0] frame_cnt,
  output logic [7:0] shadow,
  output logic       pwm
);

  logic [7:0] active;

  // Shadow holds the last software value; active picks it up only at frame start
  // so a running frame is never cut short or stretched.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      shadow <= 8'h00;
      active <= 8'h00;
    end else begin
      if (shadow_we) shadow <= wdata;
      if (load)      active <= shadow;
    end
  end

  // Registered compare; disabled channels sit at the idle (invert) level.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) pwm <= 1'b0;
    else           pwm <= (enable && (frame_cnt < active)) ^ invert;
  end

endmodule

// File: rtl/apb_led_pwm.sv
// APB completer with a shared prescaler/frame counter driving NUM_CHANNELS
// brightness-controlled LED PWM outputs. One wait state on every transfer.
module apb_led_pwm
  import apb_led_pwm_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  apb_if.completer                 apb,
  output logic [NUM_CHANNELS-1:0]  pwm_out
);

  localparam logic [7:0] CTRL_WORD     = REG_CTRL[9:2];
  localparam logic [7:0] PRESCALE_WORD = REG_PRESCALE[9:2];
  localparam logic [7:0] DUTY_WORD     = REG_DUTY_BASE[9:2];
  localparam logic [7:0] NUM_CH_W      = 8'(NUM_CHANNELS);

  logic [7:0]                  word_off;
  logic [7:0]                  duty_idx;
  logic                        sel_ctrl;
  logic                        sel_prescale;
  logic                        sel_duty;
  logic                        addr_ok;
  logic                        access_first;
  logic                        commit;
  logic                        en_rise;
  logic                        tick;
  logic                        wrap;
  logic                        load;
  logic [31:0]                 rd_mux;
  logic                        ctrl_en;
  logic                        ctrl_inv;
  logic [PRESCALE_WIDTH-1:0]   prescale;
  logic [PRESCALE_WIDTH-1:0]   pre_cnt;
  logic [7:0]                  frame_cnt;
  logic [NUM_CHANNELS*8-1:0]   duty_shadow;
  logic [NUM_CHANNELS-1:0]     duty_we;
  logic                        unused_bits;

  assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

  assign word_off     = apb.paddr[9:2];
  assign duty_idx     = word_off - DUTY_WORD;
  assign sel_ctrl     = (word_off == CTRL_WORD);
  assign sel_prescale = (word_off == PRESCALE_WORD);
  assign sel_duty     = (word_off >= DUTY_WORD) && (duty_idx < NUM_CH_W);
  assign addr_ok      = sel_ctrl || sel_prescale || sel_duty;

  // First access cycle arms pready; the write lands on the pready=1 cycle.
  assign access_first = apb.psel && apb.penable && !apb.pready;
  assign commit       = apb.psel && apb.penable && apb.pready && apb.pwrite && addr_ok;
  assign en_rise      = commit && sel_ctrl && apb.pwdata[CTRL_ENABLE_BIT] && !ctrl_en;

  assign tick = ctrl_en && (pre_cnt == prescale);
  assign wrap = tick && (frame_cnt == 8'hFF);
  assign load = wrap || en_rise;

  // Read data selection for valid offsets; unmapped offsets fall through to zero.
  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux[CTRL_ENABLE_BIT] = ctrl_en;
      rd_mux[CTRL_INVERT_BIT] = ctrl_inv;
    end else if (sel_prescale) begin
      rd_mux[PRESCALE_WIDTH-1:0] = prescale;
    end else if (sel_duty) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (duty_idx == 8'(i)) rd_mux[7:0] = duty_shadow[i*8 +: 8];
      end
    end
  end

  // APB response: pready/prdata/pslverr registered, held for exactly one cycle.
  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end else if (access_first) begin
      apb.pready  <= 1'b1;
      apb.pslverr <= !addr_ok;
      apb.prdata  <= (apb.pwrite || !addr_ok) ? '0 : rd_mux;
    end else begin
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end
  end

  // CTRL and PRESCALE registers.
  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      ctrl_en  <= 1'b0;
      ctrl_inv <= 1'b0;
      prescale <= '0;
    end else if (commit && sel_ctrl) begin
      ctrl_en  <= apb.pwdata[CTRL_ENABLE_BIT];
      ctrl_inv <= apb.pwdata[CTRL_INVERT_BIT];
    end else if (commit && sel_prescale) begin
      prescale <= apb.pwdata[PRESCALE_WIDTH-1:0];
    end
  end

  // Prescaler and frame counter; both parked at 0 while disabled so re-enable
  // always starts a fresh frame. A PRESCALE write restarts only the prescaler.
  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      pre_cnt   <= '0;
      frame_cnt <= 8'h00;
    end else if (!ctrl_en) begin
      pre_cnt   <= '0;
      frame_cnt <= 8'h00;
    end else begin
      if (commit && sel_prescale) pre_cnt <= '0;
      else if (tick)              pre_cnt <= '0;
      else                        pre_cnt <= pre_cnt + 1'b1;
      if (tick) frame_cnt <= frame_cnt + 8'h01;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign duty_we[g] = commit && sel_duty && (duty_idx == 8'(g));

    led_pwm_channel u_ch (
      .pclk      (apb.pclk),
      .preset_n  (apb.preset_n),
      .shadow_we (duty_we[g]),
      .wdata     (apb.pwdata[7:0]),
      .load      (load),
      .enable    (ctrl_en),
      .invert    (ctrl_inv),
      .frame_cnt (frame_cnt),
      .shadow    (duty_shadow[g*8 +: 8]),
      .pwm       (pwm_out[g])
    );
  end

endmodule
